alu_req_scheduler: RTL
======================

Name: alu_req_scheduler

Overview:
- Shares the single 8-bit ALU datapath of the bus master among NUM_REQ requesters using round-robin arbitration.
- Each requester presents a 12-bit instruction word (opcode in bits [5:2]) and two 8-bit operands.
- The scheduler issues the operation to the ALU and waits the fixed ALU latency.
- It then packs the result into the 12-bit serial frame and hands that frame to the serial writer over a valid/ready handshake.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..16.
- SRC_W, 2, width of the requester index; must equal clog2(NUM_REQ).
- ALU_LAT, 1, number of clock edges from ALU input change to valid alu_outdata.
- TIMEOUT, 255, cycles frame_valid may wait for frame_ready (used only with the optional feature).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- req  in  NUM_REQ  per-requester request level
- req_func  in  NUM_REQ*12  flattened instruction words; requester i occupies bits [12*i+11:12*i]
- req_data1  in  NUM_REQ*8  flattened operand A
- req_data2  in  NUM_REQ*8  flattened operand B
- gnt  out  NUM_REQ  one-hot, one-cycle accept pulse
- alu_func  out  12  instruction to the ALU
- alu_data1  out  8  operand A to the ALU
- alu_data2  out  8  operand B to the ALU
- alu_outdata  in  8  ALU result
- frame_data  out  12  packed frame
- frame_src  out  SRC_W  index of the requester that owns the frame
- frame_valid  out  1  frame available
- frame_ready  in  1  serial writer accepts frame
- busy  out  1  high in any state other than IDLE
- drop  out  1  one-cycle pulse when a frame is discarded

Behaviour:
- All outputs are registered.
- Reset values: gnt=0, alu_func=0, alu_data1=0, alu_data2=0, frame_data=0, frame_src=0, frame_valid=0, busy=0, drop=0.
- Reset also sets state=IDLE and last_grant=NUM_REQ-1, so requester 0 has first priority.
- States are IDLE, WAIT and SEND.
- IDLE:
  - If any req bit is set at edge E0, select the first set bit searching from (last_grant+1) mod NUM_REQ upward with wrap-around.
  - At E0: set gnt[sel]=1 for one cycle; copy that requester's func/data1/data2 onto the alu_* outputs; store sel; load the wait counter with ALU_LAT; go to WAIT.
  - If no req bit is set, stay in IDLE.
- WAIT:
  - alu_* outputs are held stable.
  - The counter decrements on each edge.
  - At edge E0+ALU_LAT+1, capture alu_outdata into the result register, assert frame_valid, drive frame_src=sel, and go to SEND.
- SEND:
  - frame_data, frame_src and frame_valid are held stable until frame_valid & frame_ready is sampled on an edge.
  - On that edge: clear frame_valid, set last_grant=sel, return to IDLE.
  - The next grant occurs no earlier than the following edge.
- Frame format:
  - bit0=1 (start)
  - bit1=1 (ack)
  - bits[9:2]=result[7:0]
  - bit10=1 (nack)
  - bit11=1 (stop)
- Requester protocol:
  - A requester holds req and its operands until it sees gnt.
  - Deasserting req before grant withdraws the request with no side effect.
  - req seen in WAIT or SEND is ignored until the scheduler returns to IDLE.
- Simultaneous requests: exactly one grant per operation; round-robin guarantees each held request is served within NUM_REQ operations.
- Reset mid-operation: any in-flight result is discarded, no frame is emitted, and all outputs return to reset values on the next edge.
- Without the optional feature, drop is tied to 0.

Optional Feature:
- Macro: FRAME_TIMEOUT_EN.
- When defined:
  - A counter runs while in SEND with frame_ready low.
  - When it reaches TIMEOUT, frame_valid clears, drop pulses for one cycle, last_grant updates, and the state returns to IDLE.
  - The counter clears on entry to SEND.
- When undefined: SEND waits indefinitely and drop is constant 0.

Test Plan:
- req=4'b0001, func0=12'h000 (add), data 8'h05/8'h03, ALU model returns 8'h08 -> gnt[0] pulses once; frame_data=12'hC23, frame_src=0; frame_valid rises 2 edges after the grant edge.
- req=4'b1111 held with frame_ready=1 -> gnt sequence 0,1,2,3,0; exactly one gnt bit high per operation.
- Single request with frame_ready=0 for 10 cycles -> frame_valid, frame_data and busy stay high/stable; no gnt during this time; frame accepted on the cycle ready rises.
- ALU model returns 8'hFF -> frame_data=12'hFFF; ALU returns 8'h00 -> frame_data=12'hC03.
- reset asserted while in WAIT -> next edge: busy=0, frame_valid=0, alu_*=0; no frame ever emitted for that request.
- With FRAME_TIMEOUT_EN defined and frame_ready held 0 -> after 255 SEND cycles, drop pulses once, frame_valid=0, and the next pending request is granted.

Source files
------------

// File: rtl/alu_req_scheduler_if.sv
// Frame handshake between the ALU request scheduler and the serial writer.
// master: the scheduler (drives the frame, samples ready).
// slave:  the serial writer (samples the frame, drives ready).
interface alu_req_scheduler_if #(
    parameter int SRC_W = 2
);
    logic [11:0]      frame_data;
    logic [SRC_W-1:0] frame_src;
    logic             frame_valid;
    logic             frame_ready;

    modport master (
        output frame_data,
        output frame_src,
        output frame_valid,
        input  frame_ready
    );

    modport slave (
        input  frame_data,
        input  frame_src,
        input  frame_valid,
        output frame_ready
    );
endinterface

// File: rtl/alu_req_scheduler.sv
// Round-robin scheduler sharing one 8-bit ALU among NUM_REQ requesters.
// A granted operation is issued to the ALU, its result is captured after
// ALU_LAT edges, packed into a 12-bit serial frame and offered to the
// serial writer over a valid/ready handshake.
// Optional macro FRAME_TIMEOUT_EN: discard a frame (pulse drop) after
// TIMEOUT cycles without frame_ready; otherwise SEND waits indefinitely.
module alu_req_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int SRC_W   = 2,
    parameter int ALU_LAT = 1,
    parameter int TIMEOUT = 255
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ*12-1:0]  req_func,
    input  logic [NUM_REQ*8-1:0]   req_data1,
    input  logic [NUM_REQ*8-1:0]   req_data2,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [11:0]            alu_func,
    output logic [7:0]             alu_data1,
    output logic [7:0]             alu_data2,
    input  logic [7:0]             alu_outdata,
    alu_req_scheduler_if.master    frame,
    output logic                   busy,
    output logic                   drop
);

    typedef enum logic [1:0] {IDLE, WAIT, SEND} state_t;

    localparam int unsigned      N         = NUM_REQ;
    localparam int               LAT_W     = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);
    localparam logic [SRC_W-1:0] LAST_INIT = SRC_W'(NUM_REQ - 1);

    if (NUM_REQ < 2 || NUM_REQ > 16 || SRC_W != $clog2(NUM_REQ) || TIMEOUT < 1) begin : g_param_check
        $error("alu_req_scheduler: illegal parameter set");
    end

    state_t             state, state_n;
    logic [SRC_W-1:0]   last_grant, last_n;
    logic [SRC_W-1:0]   sel, sel_n;
    logic [LAT_W-1:0]   lat_cnt, lat_n;
    logic [NUM_REQ-1:0] gnt_n;
    logic [11:0]        alu_func_n, frame_data_n;
    logic [7:0]         alu_data1_n, alu_data2_n;
    logic [SRC_W-1:0]   frame_src_n;
    logic               frame_valid_n, busy_n, drop_n;
    logic               found;
    logic [SRC_W-1:0]   pick;

`ifdef FRAME_TIMEOUT_EN
    localparam int      TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0]    to_cnt, to_n;
`endif

    // Round-robin pick: first set req bit after last_grant, wrapping around.
    always_comb begin
        int unsigned idx;
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = k + 32'(last_grant);
            if (idx >= N) idx = idx - N;
            if (!found && req[idx[SRC_W-1:0]]) begin
                found = 1'b1;
                pick  = idx[SRC_W-1:0];
            end
        end
    end

    // Next-state and next-output computation; every output is registered.
    always_comb begin
        state_n       = state;
        last_n        = last_grant;
        sel_n         = sel;
        lat_n         = lat_cnt;
        gnt_n         = '0;
        alu_func_n    = alu_func;
        alu_data1_n   = alu_data1;
        alu_data2_n   = alu_data2;
        frame_data_n  = frame.frame_data;
        frame_src_n   = frame.frame_src;
        frame_valid_n = frame.frame_valid;
        drop_n        = 1'b0;
`ifdef FRAME_TIMEOUT_EN
        to_n          = to_cnt;
`endif
        case (state)
            IDLE: begin
                if (found) begin
                    gnt_n       = NUM_REQ'(1) << pick;
                    alu_func_n  = req_func[12*pick +: 12];
                    alu_data1_n = req_data1[8*pick +: 8];
                    alu_data2_n = req_data2[8*pick +: 8];
                    sel_n       = pick;
                    lat_n       = LAT_W'(ALU_LAT);
                    state_n     = WAIT;
                end
            end
            WAIT: begin
                // Counter reaches zero on edge E0+ALU_LAT; capture on the next one.
                if (lat_cnt == '0) begin
                    frame_data_n  = {2'b11, alu_outdata, 2'b11};
                    frame_src_n   = sel;
                    frame_valid_n = 1'b1;
                    state_n       = SEND;
`ifdef FRAME_TIMEOUT_EN
                    to_n          = '0;
`endif
                end else begin
                    lat_n = lat_cnt - 1'b1;
                end
            end
            SEND: begin
                if (frame.frame_valid && frame.frame_ready) begin
                    frame_valid_n = 1'b0;
                    last_n        = sel;
                    state_n       = IDLE;
                end
`ifdef FRAME_TIMEOUT_EN
                else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                    to_n          = to_cnt + 1'b1;
                    frame_valid_n = 1'b0;
                    drop_n        = 1'b1;
                    last_n        = sel;
                    state_n       = IDLE;
                end else begin
                    to_n = to_cnt + 1'b1;
                end
`endif
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state             <= IDLE;
            last_grant        <= LAST_INIT;
            sel               <= '0;
            lat_cnt           <= '0;
            gnt               <= '0;
            alu_func          <= '0;
            alu_data1         <= '0;
            alu_data2         <= '0;
            frame.frame_data  <= '0;
            frame.frame_src   <= '0;
            frame.frame_valid <= 1'b0;
            busy              <= 1'b0;
            drop              <= 1'b0;
`ifdef FRAME_TIMEOUT_EN
            to_cnt            <= '0;
`endif
        end else begin
            state             <= state_n;
            last_grant        <= last_n;
            sel               <= sel_n;
            lat_cnt           <= lat_n;
            gnt               <= gnt_n;
            alu_func          <= alu_func_n;
            alu_data1         <= alu_data1_n;
            alu_data2         <= alu_data2_n;
            frame.frame_data  <= frame_data_n;
            frame.frame_src   <= frame_src_n;
            frame.frame_valid <= frame_valid_n;
            busy              <= busy_n;
            drop              <= drop_n;
`ifdef FRAME_TIMEOUT_EN
            to_cnt            <= to_n;
`endif
        end
    end

endmodule
